seq_detect_sched: RTL and testbench
===================================

Name: seq_detect_sched

Overview:
- Time-multiplexed scheduler that shares one Mealy "1101" sequence-detector engine among N serial bit channels.
- Each channel offers one bit per request. A round-robin arbiter grants one channel per cycle.
- The shared engine advances that channel's stored 2-bit state and reports a detection pulse tagged with the channel number.
- Per-channel saturating hit counters are readable by index. Sits between serial front-ends and the LED/debug logic.

Parameters:
- N, 4, number of requesting channels (2..8).
- CW, 2, channel index width, equal to ceil(log2 N).
- CNTW, 8, width of each per-channel hit counter.

Ports:
- clk  input  1  system clock, rising edge.
- clr  input  1  reset; asynchronous, active-high.
- req  input  N  per-channel request; bit x[i] is valid while req[i]=1.
- x  input  N  per-channel serial data bit.
- chan_clr  input  N  synchronous per-channel clear of engine state and hit counter.
- gnt  output  N  one-hot grant; combinational; x[i] is consumed on the cycle gnt[i]=1.
- hit  output  1  registered detection pulse, 1 cycle wide.
- hit_ch  output  CW  channel that produced hit; registered.
- rd_sel  input  CW  counter read index.
- rd_cnt  output  CNTW  hit counter of channel rd_sel; combinational mux.

Behaviour:
- Reset (clr=1, asynchronous):
  - all channel states = A; all counters = 0; rr pointer = 0; hit = 0; hit_ch = 0.
  - gnt = 0 while clr is high.
  - Reset mid-operation discards the in-flight bit and any pending hit.
- Arbitration:
  - eligible = req & ~chan_clr.
  - Search eligible from ptr upward, wrapping at N-1 to 0; the first set bit gets gnt.
  - If a grant occurs, ptr <= granted index + 1 (mod N). If nothing is eligible, ptr holds and gnt = 0.
  - A requester holds req and x until it sees gnt. It may deassert req at any time without penalty.
- Engine (per granted channel g, stored state S[g] in {A=00, B=01, C=10, D=11}):
  - x=0: A->A, B->A, C->D, D->A.
  - x=1: A->B, B->C, C->C, D->B.
  - Detection fires when S[g]=D and x=1. Overlapping sequences are allowed; D with x=1 goes to B.
  - Non-granted channels keep their state unchanged.
- Hit timing:
  - hit and hit_ch are registered, so they appear on the cycle after the grant. Latency is 1 clk.
  - On a non-hit cycle: hit = 0 and hit_ch holds its last value.
- Counters:
  - On a hit, cnt[g] increments, saturating at 2^CNTW-1. At saturation hit still pulses.
- chan_clr[i]=1 at a clock edge:
  - sets S[i]=A and cnt[i]=0.
  - Channel i is masked from arbitration that cycle, so its bit is not consumed.
  - Multiple channels may be cleared in the same cycle.
- Simultaneous events:
  - A hit on channel g and chan_clr[g] cannot coincide, because g is masked.
  - rd_sel equal to the counter being updated: rd_cnt shows the pre-update value until the next edge.
- rd_sel >= N returns 0.

Test Plan:
- Reset, then channel 0 alone with req=1 for 4 cycles, bits 1,1,0,1 -> gnt[0] high each cycle; hit=1 with hit_ch=0 one cycle after the 4th grant; rd_cnt(sel=0)=1.
- Channel 0 sends 1,1,0,1,1,0,1 (overlap) -> two hits, on the cycles after grants 4 and 7; cnt[0]=2.
- Channels 1 and 2 both request continuously; ch1 streams 1,1,0,1 and ch2 streams 0,0,0,0 -> gnt alternates 1,2,1,2,...; exactly one hit with hit_ch=1, after ch1's 4th grant; cnt[2]=0.
- All 4 channels request every cycle with ptr=0 -> grant order 0,1,2,3,0,...; no channel is granted twice before the others are each granted once.
- Channel 3 reaches state D (bits 1,1,0), then chan_clr[3]=1 with req[3]=1 -> gnt[3]=0 that cycle; next bit 1 produces no hit; cnt[3]=0.
- CNTW=8: drive 256 detections on channel 0 -> cnt[0]=255 and hit still pulses. Then assert clr asynchronously between edges mid-sequence -> all outputs 0 immediately; ptr=0; the next 1,1,0,1 yields exactly one hit.

Source files
------------

// File: rtl/seq_detect_sched.sv
// Round-robin scheduler sharing one Mealy "1101" detector among N serial channels.
// Each channel keeps its own 2-bit detector state and a saturating hit counter.
module seq_detect_sched #(
  parameter int N    = 4,
  parameter int CW   = 2,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    x,
  input  logic [N-1:0]    chan_clr,
  output logic [N-1:0]    gnt,
  output logic            hit,
  output logic [CW-1:0]   hit_ch,
  input  logic [CW-1:0]   rd_sel,
  output logic [CNTW-1:0] rd_cnt
);

  typedef enum logic [1:0] {
    ST_A = 2'b00,
    ST_B = 2'b01,
    ST_C = 2'b10,
    ST_D = 2'b11
  } state_t;

  logic [N-1:0]    eligible;
  logic [CW-1:0]   ptr_reg;
  logic [CW-1:0]   ptr_next;
  logic            grant_any;
  logic [CW-1:0]   grant_idx;
  logic [CW-1:0]   scan_idx;
  int              scan_int;

  state_t          state_vec [N];
  logic [CNTW-1:0] cnt_vec   [N];
  state_t          cur_state;
  logic            cur_x;
  state_t          state_next;
  logic            detect;

  logic            hit_reg;
  logic [CW-1:0]   hit_ch_reg;

  // A channel being cleared this cycle must not have its bit consumed.
  assign eligible = req & ~chan_clr;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_int  = 0;
    scan_idx  = '0;
    for (int k = 0; k < N; k++) begin
      scan_int = int'(ptr_reg) + k;
      if (scan_int >= N) begin
        scan_int = scan_int - N;
      end
      scan_idx = CW'(scan_int);
      if (!grant_any && eligible[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
    if (clr) begin
      grant_any = 1'b0;
    end
  end

  always_comb begin
    gnt = '0;
    if (grant_any) begin
      gnt[grant_idx] = 1'b1;
    end
  end

  assign ptr_next = (int'(grant_idx) == N - 1) ? '0 : grant_idx + CW'(1);

  // Shared engine: next state and Mealy detect for the granted channel only.
  always_comb begin
    cur_state  = state_vec[grant_idx];
    cur_x      = x[grant_idx];
    state_next = ST_A;
    case (cur_state)
      ST_A: state_next = cur_x ? ST_B : ST_A;
      ST_B: state_next = cur_x ? ST_C : ST_A;
      ST_C: state_next = cur_x ? ST_C : ST_D;
      ST_D: state_next = cur_x ? ST_B : ST_A;
      default: state_next = ST_A;
    endcase
    detect = grant_any && (cur_state == ST_D) && cur_x;
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_ch
    state_t          state_reg;
    logic [CNTW-1:0] cnt_reg;

    always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
        state_reg <= ST_A;
        cnt_reg   <= '0;
      end else if (chan_clr[gi]) begin
        state_reg <= ST_A;
        cnt_reg   <= '0;
      end else if (gnt[gi]) begin
        state_reg <= state_next;
        if (detect && (cnt_reg != {CNTW{1'b1}})) begin
          cnt_reg <= cnt_reg + CNTW'(1);
        end
      end
    end

    assign state_vec[gi] = state_reg;
    assign cnt_vec[gi]   = cnt_reg;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ptr_reg    <= '0;
      hit_reg    <= 1'b0;
      hit_ch_reg <= '0;
    end else begin
      hit_reg <= detect;
      if (detect) begin
        hit_ch_reg <= grant_idx;
      end
      if (grant_any) begin
        ptr_reg <= ptr_next;
      end
    end
  end

  assign hit    = hit_reg;
  assign hit_ch = hit_ch_reg;

  // Indices past the last channel read as zero.
  always_comb begin
    rd_cnt = '0;
    if (int'(rd_sel) < N) begin
      rd_cnt = cnt_vec[rd_sel];
    end
  end

endmodule

// File: tb/tb_seq_detect_sched.sv
// Directed bench for seq_detect_sched: hand-computed grants, hits and counter values.
module tb_seq_detect_sched;
  localparam int N    = 4;
  localparam int CW   = 2;
  localparam int CNTW = 8;

  logic            clk = 1'b0;
  logic            clr;
  logic [N-1:0]    req;
  logic [N-1:0]    x;
  logic [N-1:0]    chan_clr;
  logic [N-1:0]    gnt;
  logic            hit;
  logic [CW-1:0]   hit_ch;
  logic [CW-1:0]   rd_sel;
  logic [CNTW-1:0] rd_cnt;

  int              checks = 0;
  int              errors = 0;
  logic [CW-1:0]   exp_hc;

  always #5 clk = ~clk;

  seq_detect_sched #(.N(N), .CW(CW), .CNTW(CNTW)) dut (
    .clk      (clk),
    .clr      (clr),
    .req      (req),
    .x        (x),
    .chan_clr (chan_clr),
    .gnt      (gnt),
    .hit      (hit),
    .hit_ch   (hit_ch),
    .rd_sel   (rd_sel),
    .rd_cnt   (rd_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: check the combinational grant, then the registered hit.
  task automatic cyc(input string tag, input logic [N-1:0] r, input logic [N-1:0] xv,
                     input logic [N-1:0] cc, input logic [N-1:0] eg,
                     input logic eh, input logic [CW-1:0] ehc);
    req = r;
    x = xv;
    chan_clr = cc;
    #1;
    check({tag, " gnt"}, 32'(gnt), 32'(eg));
    @(posedge clk);
    #1;
    if (eh) exp_hc = ehc;
    check({tag, " hit"}, 32'(hit), 32'(eh));
    check({tag, " hit_ch"}, 32'(hit_ch), 32'(exp_hc));
  endtask

  task automatic check_cnt(input string tag, input logic [CW-1:0] sel, input logic [CNTW-1:0] exp);
    rd_sel = sel;
    #1;
    check(tag, 32'(rd_cnt), 32'(exp));
  endtask

  logic s2_bits [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic s2_hits [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic first4  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  logic next3   [3] = '{1'b1, 1'b0, 1'b1};

  initial begin
    clr = 1'b1;
    req = '1;
    x = '0;
    chan_clr = '0;
    rd_sel = '0;
    exp_hc = '0;
    #1;
    check("rst gnt", 32'(gnt), 32'(0));
    @(posedge clk);
    #1;
    check("rst hit", 32'(hit), 32'(0));
    check("rst hit_ch", 32'(hit_ch), 32'(0));
    for (int i = 0; i < N; i++) check_cnt("rst cnt", CW'(i), 8'd0);
    req = '0;
    #2 clr = 1'b0;

    // Channel 0 alone: 1101 -> one hit
    cyc("s1b1", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'd0);
    cyc("s1b2", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'd0);
    cyc("s1b3", 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0);
    cyc("s1b4", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0);
    req = '0;
    check_cnt("s1 cnt0", 2'd0, 8'd1);
    cyc("s1idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);

    // Overlapping 1101101 after clearing channel 0
    cyc("s2clr", 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0, 2'd0);
    check_cnt("s2 cnt0 cleared", 2'd0, 8'd0);
    for (int i = 0; i < 7; i++)
      cyc("s2", 4'b0001, {3'b000, s2_bits[i]}, 4'b0000, 4'b0001, s2_hits[i], 2'd0);
    check_cnt("s2 cnt0", 2'd0, 8'd2);

    // Channels 1 and 2 compete; ch1 streams 1101, ch2 streams zeros
    cyc("s3c1", 4'b0110, 4'b0010, 4'b0000, 4'b0010, 1'b0, 2'd0);
    cyc("s3c2", 4'b0110, 4'b0010, 4'b0000, 4'b0100, 1'b0, 2'd0);
    cyc("s3c3", 4'b0110, 4'b0010, 4'b0000, 4'b0010, 1'b0, 2'd0);
    cyc("s3c4", 4'b0110, 4'b0000, 4'b0000, 4'b0100, 1'b0, 2'd0);
    cyc("s3c5", 4'b0110, 4'b0000, 4'b0000, 4'b0010, 1'b0, 2'd0);
    cyc("s3c6", 4'b0110, 4'b0010, 4'b0000, 4'b0100, 1'b0, 2'd0);
    cyc("s3c7", 4'b0110, 4'b0010, 4'b0000, 4'b0010, 1'b1, 2'd1);
    cyc("s3c8", 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b0, 2'd0);
    req = '0;
    check_cnt("s3 cnt1", 2'd1, 8'd1);
    check_cnt("s3 cnt2", 2'd2, 8'd0);

    // Bring ptr back to 0, then all four request: strict rotation
    cyc("s4pre", 4'b1000, 4'b0000, 4'b0000, 4'b1000, 1'b0, 2'd0);
    for (int i = 0; i < 8; i++)
      cyc("s4rr", 4'b1111, 4'b0000, 4'b0000, 4'(1 << (i % 4)), 1'b0, 2'd0);

    // Channel 3 to state D, then clear with request held
    cyc("s5b1", 4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b0, 2'd0);
    cyc("s5b2", 4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b0, 2'd0);
    cyc("s5b3", 4'b1000, 4'b0000, 4'b0000, 4'b1000, 1'b0, 2'd0);
    cyc("s5clr", 4'b1000, 4'b1000, 4'b1000, 4'b0000, 1'b0, 2'd0);
    cyc("s5post", 4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b0, 2'd0);
    check_cnt("s5 cnt3", 2'd3, 8'd0);
    // Two channels cleared together; masked ch0/ch1 are skipped
    cyc("s5multi", 4'b1111, 4'b0000, 4'b0011, 4'b0100, 1'b0, 2'd0);
    check_cnt("s5 cnt0", 2'd0, 8'd0);
    check_cnt("s5 cnt1", 2'd1, 8'd0);

    // 256 detections on channel 0: counter saturates, hit keeps pulsing
    for (int d = 0; d < 256; d++) begin
      if (d == 0) begin
        for (int b = 0; b < 4; b++)
          cyc("s6", 4'b0001, {3'b000, first4[b]}, 4'b0000, 4'b0001, (b == 3), 2'd0);
      end else begin
        for (int b = 0; b < 3; b++)
          cyc("s6", 4'b0001, {3'b000, next3[b]}, 4'b0000, 4'b0001, (b == 2), 2'd0);
      end
      if (d == 254) check_cnt("s6 cnt0 at 255 hits", 2'd0, 8'd255);
    end
    check_cnt("s6 cnt0 saturated", 2'd0, 8'd255);

    // Channel 0 into D, channel 1 produces a hit, then async reset mid-cycle
    cyc("s7d1", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'd0);
    cyc("s7d2", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'd0);
    cyc("s7d3", 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0);
    for (int b = 0; b < 4; b++)
      cyc("s7ch1", 4'b0010, {2'b00, first4[b], 1'b0}, 4'b0000, 4'b0010, (b == 3), 2'd1);
    req = 4'b0001;
    x = 4'b0001;
    rd_sel = 2'd0;
    #1;
    check("s7 inflight gnt", 32'(gnt), 32'(4'b0001));
    #2 clr = 1'b1;
    exp_hc = '0;
    #1;
    check("s7 clr hit", 32'(hit), 32'(0));
    check("s7 clr hit_ch", 32'(hit_ch), 32'(0));
    check("s7 clr gnt", 32'(gnt), 32'(0));
    check("s7 clr cnt0", 32'(rd_cnt), 32'(0));
    @(posedge clk);
    #1;
    check("s7 held gnt", 32'(gnt), 32'(0));
    check("s7 held hit", 32'(hit), 32'(0));
    #2 clr = 1'b0;

    // ptr is 0 again; fresh 1101 on channel 0 yields exactly one hit
    cyc("s8b1", 4'b1111, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'd0);
    cyc("s8b2", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'd0);
    cyc("s8b3", 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0);
    cyc("s8b4", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0);
    req = '0;
    check_cnt("s8 cnt0", 2'd0, 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
